// File: rtl/neuron_pkg.sv
// Shared types and helpers for the perceptron neuron datapath.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 40;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Registered multiply-accumulate: acc += a*b when enabled, synchronous clear.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod_s;

  assign prod_s = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Accumulator register; wraps modulo 2^ACC_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= {ACC_W{1'b0}};
    end else if (clr) begin
      acc <= {ACC_W{1'b0}};
    end else if (en) begin
      acc <= acc + ACC_W'(prod_s);
    end
  end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Streams one input vector against a neuron's weight ROM, accumulates the dot
// product and presents {sum, fire} on a valid/ready result port.
module neuron_mac_sequencer
  import neuron_pkg::*;
#(
  parameter int N_INPUTS  = 10,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BASE_ADDR = 1,
  parameter int THRESHOLD = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_fire
);

  localparam int IDX_W = clog2(N_INPUTS + 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [IDX_W-1:0]  idx_r;
  logic              mac_en_r;
  logic [DATA_W-1:0] data_q_r;
  logic              in_ready_s;
  logic              accept_s;
  logic              last_s;
  logic              mac_clr_s;
  logic [ACC_W-1:0]  acc_s;

  assign in_ready_s = (state_r == RUN) && (idx_r < IDX_W'(N_INPUTS));
  assign in_ready   = in_ready_s;
  assign accept_s   = in_valid && in_ready_s;
  assign last_s     = accept_s && (idx_r == IDX_W'(N_INPUTS - 1));
  assign mac_clr_s  = (state_r == IDLE) && start;

  // Next-state logic; start outside IDLE and handshakes outside DONE are ignored.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DRAIN;
        else        state_nxt_s = RUN;
      end
      DRAIN: state_nxt_s = DONE;
      DONE: begin
        if (out_valid && out_ready) state_nxt_s = IDLE;
        else                        state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with busy registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != IDLE);
    end
  end

  // Element index, ROM address and the data/enable pipe feeding the MAC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r    <= {IDX_W{1'b0}};
      rom_addr <= {DATA_W{1'b0}};
      data_q_r <= {DATA_W{1'b0}};
      mac_en_r <= 1'b0;
    end else if (mac_clr_s) begin
      idx_r    <= {IDX_W{1'b0}};
      mac_en_r <= 1'b0;
    end else if (accept_s) begin
      rom_addr <= DATA_W'(BASE_ADDR) + DATA_W'(idx_r);
      data_q_r <= in_data;
      mac_en_r <= 1'b1;
      idx_r    <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      mac_en_r <= 1'b0;
    end
  end

  neuron_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(mac_clr_s),
    .en (mac_en_r),
    .a  (data_q_r),
    .b  (rom_dout),
    .acc(acc_s)
  );

  // Result capture on the first DONE cycle, held until the consumer accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= {ACC_W{1'b0}};
      out_fire  <= 1'b0;
    end else if (state_r == DONE) begin
      if (!out_valid) begin
        out_sum   <= acc_s;
        out_fire  <= (acc_s >= ACC_W'(THRESHOLD));
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Scoreboard bench for neuron_mac_sequencer against the neuron_rom0 weight table.
module tb_neuron_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] rom_addr;
  logic [15:0] rom_dout;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_sum;
  logic        out_fire;

  typedef struct {
    logic [39:0] sum;
    logic        fire;
  } res_t;

  res_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_popped = 0;

  always #5 clk = ~clk;

  neuron_mac_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_fire (out_fire)
  );

  // neuron_rom0 contents; rom_addr is the ROM's registered address.
  function automatic logic [15:0] rom_w(input logic [15:0] a);
    case (a)
      16'd1:   return 16'd1;
      16'd2:   return 16'd3;
      16'd3:   return 16'd4;
      16'd4:   return 16'd5;
      16'd5:   return 16'd6;
      16'd6:   return 16'd8;
      16'd7:   return 16'd9;
      16'd8:   return 16'd10;
      16'd9:   return 16'd11;
      16'd10:  return 16'd13;
      default: return 16'd0;
    endcase
  endfunction

  assign rom_dout = rom_w(rom_addr);

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void push(input logic [39:0] s, input logic f);
    res_t r;
    r.sum  = s;
    r.fire = f;
    exp_q.push_back(r);
  endfunction

  // Monitor: every result handshake pops and compares one expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got sum %0d with no expected entry", out_sum);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        n_popped++;
        check("out_sum", 64'(out_sum), 64'(e.sum));
        check("out_fire", 64'(out_fire), 64'(e.fire));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] v [10], input int n, input int max_bubble, input bit chk_addr);
    for (int i = 0; i < n; i++) begin
      int b;
      int cnt;
      b = (max_bubble > 0) ? int'($urandom_range(max_bubble, 0)) : 0;
      in_valid = 1'b0;
      repeat (b) tick();
      in_valid = 1'b1;
      in_data  = v[i];
      cnt = 0;
      while (!in_ready && cnt < 50) begin
        tick();
        cnt++;
      end
      if (cnt == 50) check("in_ready_timeout", 64'(in_ready), 64'd1);
      tick();
      if (chk_addr) check($sformatf("rom_addr_%0d", i), 64'(rom_addr), 64'(i + 1));
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      tick();
      cnt++;
    end
    check("out_valid_wait", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
    end
    check("idle_wait", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [15:0] vec [10];
    int cnt;

    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 16'd0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_fire", 64'(out_fire), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();

    // 1: ten ones back-to-back, address stepping and 2-clk latency
    for (int i = 0; i < 10; i++) vec[i] = 16'd1;
    push(40'd70, 1'b0);
    do_start();
    check("t1_busy", 64'(busy), 64'd1);
    send_vec(vec, 10, 0, 1'b1);
    check("t1_in_ready_drop", 64'(in_ready), 64'd0);
    tick();
    check("t1_lat_1clk", 64'(out_valid), 64'd0);
    tick();
    check("t1_lat_2clk", 64'(out_valid), 64'd1);
    wait_idle();

    // 2: 0..9 with bubbles
    for (int i = 0; i < 10; i++) vec[i] = 16'(i);
    push(40'd419, 1'b1);
    do_start();
    send_vec(vec, 10, 2, 1'b0);
    check("t2_in_ready_drop", 64'(in_ready), 64'd0);
    wait_idle();

    // 3: result held under backpressure, start and in_valid ignored
    for (int i = 0; i < 10; i++) vec[i] = 16'(9 - i);
    push(40'd211, 1'b1);
    out_ready = 1'b0;
    do_start();
    send_vec(vec, 10, 0, 1'b0);
    wait_out_valid();
    for (int k = 0; k < 20; k++) begin
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_sum", 64'(out_sum), 64'd211);
      check("t3_hold_fire", 64'(out_fire), 64'd1);
      if (k == 11) check("t3_no_accept", 64'(in_ready), 64'd0);
      start    = (k == 5);
      in_valid = (k == 10);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("t3_busy_held", 64'(busy), 64'd1);
    out_ready = 1'b1;
    wait_idle();

    // 4: reset after the 5th accept, then a fresh vector of twos
    for (int i = 0; i < 10; i++) vec[i] = 16'd3;
    do_start();
    send_vec(vec, 5, 0, 1'b0);
    rst = 1'b1;
    tick();
    check("t4_rst_out_valid", 64'(out_valid), 64'd0);
    check("t4_rst_out_sum", 64'(out_sum), 64'd0);
    check("t4_rst_out_fire", 64'(out_fire), 64'd0);
    check("t4_rst_rom_addr", 64'(rom_addr), 64'd0);
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) vec[i] = 16'd2;
    push(40'd140, 1'b1);
    do_start();
    send_vec(vec, 10, 0, 1'b0);
    wait_idle();

    // 5: full-scale inputs, back-to-back vectors
    for (int i = 0; i < 10; i++) vec[i] = 16'hFFFF;
    push(40'd4587450, 1'b1);
    push(40'd4587450, 1'b1);
    do_start();
    send_vec(vec, 10, 0, 1'b0);
    wait_out_valid();
    tick();
    check("t5_idle_after_hs", 64'(busy), 64'd0);
    do_start();
    send_vec(vec, 10, 0, 1'b0);
    wait_idle();

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("result_count", 64'(n_popped), 64'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
